wb_load_commit: RTL and testbench

WB_LOAD_COMMIT -- requirements
Module: wb_load_commit

---
 rtl/wb_load_commit_if.sv | 46 ++++
 rtl/wb_load_commit.sv | 151 +++++++++++++++
 tb/tb_wb_load_commit.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_load_commit_if.sv
// Writeback/load-commit bus: retiring instruction, memory response and commit results.
// The misalign_err signal exists only when WB_MISALIGN_CHK_EN is defined.
interface wb_load_commit_if #(
    parameter int DATA_W  = 32,
    parameter int ORDER_W = 64
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic               in_valid;
    logic               is_load;
    logic [2:0]         funct3;
    logic [OFF_W-1:0]   addr_lo;
    logic [DATA_W-1:0]  alu_result;
    logic [4:0]         rd_s_in;
    logic               regf_we_in;
    logic [DATA_W-1:0]  dmem_rdata;
    logic               dmem_resp;
    logic               freeze;
    logic [DATA_W-1:0]  rd_v;
    logic [4:0]         rd_s;
    logic               regf_we;
    logic               commit;
    logic [ORDER_W-1:0] order;
    logic               load_stall;
`ifdef WB_MISALIGN_CHK_EN
    logic               misalign_err;
`endif

    modport master (
        output in_valid, is_load, funct3, addr_lo, alu_result, rd_s_in, regf_we_in,
               dmem_rdata, dmem_resp, freeze,
        input  rd_v, rd_s, regf_we, commit, order, load_stall
`ifdef WB_MISALIGN_CHK_EN
        , input misalign_err
`endif
    );

    modport slave (
        input  in_valid, is_load, funct3, addr_lo, alu_result, rd_s_in, regf_we_in,
               dmem_rdata, dmem_resp, freeze,
        output rd_v, rd_s, regf_we, commit, order, load_stall
`ifdef WB_MISALIGN_CHK_EN
        , output misalign_err
`endif
    );
endinterface

// File: rtl/wb_load_commit.sv
// Writeback stage: waits for load data, aligns/extends it and retires one instruction per cycle.
// Optional misaligned-access check is enabled by defining WB_MISALIGN_CHK_EN.
module wb_load_commit #(
    parameter int DATA_W  = 32,
    parameter int ORDER_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_load_commit_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t             state;
    state_t             state_nx;
    logic               commit_c;
    logic               capture_c;
    logic               stall_c;
    logic [DATA_W-1:0]  hold_q;
    logic [ORDER_W-1:0] order_q;
    logic               load_path;
    logic [DATA_W-1:0]  src;
    logic [OFF_W-1:0]   off_h;
    logic [OFF_W-1:0]   off_w;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [31:0]        word_v;
    logic [DATA_W-1:0]  load_v;
    logic               supported;
    logic               load_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A frozen response is parked in the hold register until the freeze lifts.
    always_comb begin
        state_nx  = state;
        commit_c  = 1'b0;
        capture_c = 1'b0;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!bus.is_load) begin
                        commit_c = !bus.freeze;
                    end else if (!bus.dmem_resp) begin
                        stall_c  = 1'b1;
                        state_nx = WAIT;
                    end else if (bus.freeze) begin
                        capture_c = 1'b1;
                        state_nx  = HOLD;
                    end else begin
                        commit_c = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (bus.dmem_resp) begin
                    if (bus.freeze) begin
                        capture_c = 1'b1;
                        state_nx  = HOLD;
                    end else begin
                        commit_c = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            HOLD: begin
                stall_c = 1'b1;
                if (!bus.freeze) begin
                    commit_c = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         hold_q <= '0;
        else if (capture_c) hold_q <= bus.dmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        order_q <= '0;
        else if (commit_c) order_q <= order_q + 1'b1;
    end

    assign load_path = bus.is_load | (state != IDLE);
    assign src       = (state == HOLD) ? hold_q : bus.dmem_rdata;
    assign off_h     = bus.addr_lo & ~OFF_W'(1);
    assign off_w     = bus.addr_lo & ~OFF_W'(3);
    assign byte_v    = 8'(src >> {bus.addr_lo, 3'b000});
    assign half_v    = 16'(src >> {off_h, 3'b000});
    assign word_v    = 32'(src >> {off_w, 3'b000});

    always_comb begin
        load_v    = '0;
        supported = 1'b1;
        case (bus.funct3)
            3'b000:  load_v = DATA_W'($signed(byte_v));
            3'b100:  load_v = DATA_W'(byte_v);
            3'b001:  load_v = DATA_W'($signed(half_v));
            3'b101:  load_v = DATA_W'(half_v);
            3'b010:  load_v = DATA_W'($signed(word_v));
            3'b110: begin
                if (DATA_W == 64) load_v = DATA_W'(word_v);
                else              supported = 1'b0;
            end
            3'b011: begin
                if (DATA_W == 64) load_v = src;
                else              supported = 1'b0;
            end
            default: supported = 1'b0;
        endcase
    end

`ifdef WB_MISALIGN_CHK_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (bus.funct3)
            3'b001, 3'b101: misaligned = bus.addr_lo[0];
            3'b010:         misaligned = |bus.addr_lo[1:0];
            3'b110:         misaligned = (DATA_W == 64) && (|bus.addr_lo[1:0]);
            3'b011:         misaligned = (DATA_W == 64) && (|bus.addr_lo);
            default:        misaligned = 1'b0;
        endcase
    end

    assign load_ok          = supported & ~misaligned;
    assign bus.misalign_err = bus.commit & load_path & misaligned;
`else
    assign load_ok = supported;
`endif

    // Unsupported or rejected loads still retire but never write the register file.
    assign bus.commit     = commit_c & rst_n;
    assign bus.load_stall = stall_c & rst_n;
    assign bus.order      = order_q;
    assign bus.rd_s       = bus.rd_s_in;
    assign bus.regf_we    = bus.regf_we_in & bus.commit & (~load_path | load_ok);
    assign bus.rd_v       = !bus.commit ? '0 :
                            !load_path  ? bus.alu_result :
                            supported   ? load_v : '0;
endmodule

// File: tb/tb_wb_load_commit.sv
// Bench for wb_load_commit: a 32-bit (4-bit order) and a 64-bit instance share one stimulus stream.
// Vector table, hand sequences for stall/hold/reset, then random traffic against a queue-free model.
module tb_wb_load_commit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_load_commit_if #(.DATA_W(32), .ORDER_W(4))  bus32 ();
    wb_load_commit_if #(.DATA_W(64), .ORDER_W(64)) bus64 ();

    wb_load_commit #(.DATA_W(32), .ORDER_W(4))  dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    wb_load_commit #(.DATA_W(64), .ORDER_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

    typedef struct {
        logic        in_valid;
        logic        is_load;
        logic [2:0]  funct3;
        logic [2:0]  addr;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        we_in;
        logic        resp;
        logic        freeze;
    } stim_t;

    typedef struct {
        logic        commit;
        logic        stall;
        logic        we32;
        logic        we64;
        logic        mis32;
        logic        mis64;
        logic [63:0] v32;
        logic [63:0] v64;
    } exp_t;

    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  ord32 = 4'd0;
    logic [63:0] ord64 = 64'd0;
    stim_t       cur;
    bit          m_pend = 1'b0;
    bit          m_held = 1'b0;
    logic [63:0] m_word = 64'd0;
    vec_t        vecs[12];

    function automatic stim_t st(logic iv, logic ld, logic [2:0] f3, logic [2:0] a, logic [63:0] alu,
                                 logic [63:0] rdata, logic [4:0] rd, logic we, logic resp, logic frz);
        stim_t s;
        s.in_valid = iv; s.is_load = ld; s.funct3 = f3; s.addr = a; s.alu = alu;
        s.rdata = rdata; s.rd = rd; s.we_in = we; s.resp = resp; s.freeze = frz;
        return s;
    endfunction

    function automatic exp_t mk(logic c, logic stl, logic [63:0] v32, logic [63:0] v64, logic we32, logic we64);
        exp_t e;
        e.commit = c; e.stall = stl; e.v32 = v32; e.v64 = v64;
        e.we32 = we32; e.we64 = we64; e.mis32 = 1'b0; e.mis64 = 1'b0;
        return e;
    endfunction

    function automatic vec_t vec(string n, stim_t s, exp_t e);
        vec_t v;
        v.name = n; v.s = s; v.e = e;
        return v;
    endfunction

    // Reference extraction: pick the naturally-aligned field with plain shifts and masks.
    function automatic logic [63:0] loadValue(input int w, input logic [2:0] f3, input logic [2:0] a,
                                              input logic [63:0] raw, output bit ok, output bit mis);
        logic [63:0] word;
        logic [63:0] mask;
        logic [63:0] v;
        int off;
        int boff;
        int nbits;
        bit sgn;
        word  = (w == 32) ? (raw & 64'hFFFF_FFFF) : raw;
        off   = (w == 32) ? (int'(a) % 4) : int'(a);
        ok    = 1'b1;
        mis   = 1'b0;
        boff  = 0;
        nbits = 64;
        sgn   = (f3 < 3'd4);
        case (f3)
            3'd0, 3'd4: begin nbits = 8;  boff = off; end
            3'd1, 3'd5: begin nbits = 16; boff = off - off % 2; mis = (off % 2) != 0; end
            3'd2:       begin nbits = 32; boff = off - off % 4; mis = (off % 4) != 0; end
            3'd6:       begin nbits = 32; boff = off - off % 4; mis = (off % 4) != 0; ok = (w == 64); end
            3'd3:       begin nbits = 64; mis = (off != 0); ok = (w == 64); end
            default:    ok = 1'b0;
        endcase
        v = word >> (8 * boff);
        if (nbits < 64) begin
            mask = (64'd1 << nbits) - 64'd1;
            v = v & mask;
            if (sgn && v[nbits-1]) v = v | ~mask;
        end
        if (w == 32) v = v & 64'hFFFF_FFFF;
        mis = mis && ok;
        return ok ? v : 64'd0;
    endfunction

    // Reference retire behaviour: a load is "pending" until data arrives, "held" if data came while frozen.
    task automatic modelStep(input stim_t s, output exp_t e);
        bit busy, lp, ok32, ok64, mis32, mis64, bad32, bad64;
        logic [63:0] word, lv32, lv64;
        busy     = m_pend || m_held;
        lp       = busy || (s.in_valid && s.is_load);
        e.commit = !s.freeze && (lp ? (m_held || s.resp) : s.in_valid);
        e.stall  = busy || (s.in_valid && s.is_load && !s.resp);
        word     = m_held ? m_word : s.rdata;
        lv32     = loadValue(32, s.funct3, s.addr, word, ok32, mis32);
        lv64     = loadValue(64, s.funct3, s.addr, word, ok64, mis64);
`ifdef WB_MISALIGN_CHK_EN
        bad32 = !ok32 || mis32;
        bad64 = !ok64 || mis64;
`else
        bad32 = !ok32;
        bad64 = !ok64;
`endif
        e.v32   = !e.commit ? 64'd0 : lp ? lv32 : (s.alu & 64'hFFFF_FFFF);
        e.v64   = !e.commit ? 64'd0 : lp ? lv64 : s.alu;
        e.we32  = s.we_in && e.commit && !(lp && bad32);
        e.we64  = s.we_in && e.commit && !(lp && bad64);
        e.mis32 = e.commit && lp && mis32;
        e.mis64 = e.commit && lp && mis64;
        if (e.commit) begin
            m_pend = 1'b0;
            m_held = 1'b0;
        end else if (lp && !m_held && s.resp) begin
            m_held = 1'b1;
            m_pend = 1'b0;
            m_word = s.rdata;
        end else if (lp && !m_held) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic driveInputs(input stim_t s);
        cur = s;
        bus32.in_valid = s.in_valid;  bus64.in_valid = s.in_valid;
        bus32.is_load = s.is_load;    bus64.is_load = s.is_load;
        bus32.funct3 = s.funct3;      bus64.funct3 = s.funct3;
        bus32.addr_lo = s.addr[1:0];  bus64.addr_lo = s.addr;
        bus32.alu_result = s.alu[31:0];   bus64.alu_result = s.alu;
        bus32.dmem_rdata = s.rdata[31:0]; bus64.dmem_rdata = s.rdata;
        bus32.rd_s_in = s.rd;         bus64.rd_s_in = s.rd;
        bus32.regf_we_in = s.we_in;   bus64.regf_we_in = s.we_in;
        bus32.dmem_resp = s.resp;     bus64.dmem_resp = s.resp;
        bus32.freeze = s.freeze;      bus64.freeze = s.freeze;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        driveInputs(s);
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        @(negedge clk);
        cmp({name, ".commit32"}, 64'(bus32.commit), 64'(e.commit));
        cmp({name, ".commit64"}, 64'(bus64.commit), 64'(e.commit));
        cmp({name, ".stall32"},  64'(bus32.load_stall), 64'(e.stall));
        cmp({name, ".stall64"},  64'(bus64.load_stall), 64'(e.stall));
        cmp({name, ".we32"},     64'(bus32.regf_we), 64'(e.we32));
        cmp({name, ".we64"},     64'(bus64.regf_we), 64'(e.we64));
        cmp({name, ".rdv32"},    64'(bus32.rd_v), e.v32);
        cmp({name, ".rdv64"},    bus64.rd_v, e.v64);
        cmp({name, ".rds32"},    64'(bus32.rd_s), 64'(cur.rd));
        cmp({name, ".rds64"},    64'(bus64.rd_s), 64'(cur.rd));
        cmp({name, ".order32"},  64'(bus32.order), 64'(ord32));
        cmp({name, ".order64"},  bus64.order, ord64);
`ifdef WB_MISALIGN_CHK_EN
        cmp({name, ".mis32"},    64'(bus32.misalign_err), 64'(e.mis32));
        cmp({name, ".mis64"},    64'(bus64.misalign_err), 64'(e.mis64));
`endif
        if (e.commit) begin
            ord32 = ord32 + 4'd1;
            ord64 = ord64 + 64'd1;
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        driveInputs(st(1'b1, 1'b0, 3'd0, 3'd0, 64'h77, 64'h0, 5'd3, 1'b1, 1'b1, 1'b0));
        rst_n = 1'b0;
        #1;
        ord32 = 4'd0;
        ord64 = 64'd0;
        cmp("reset.commit32", 64'(bus32.commit), 64'd0);
        cmp("reset.commit64", 64'(bus64.commit), 64'd0);
        cmp("reset.we32",     64'(bus32.regf_we), 64'd0);
        cmp("reset.we64",     64'(bus64.regf_we), 64'd0);
        cmp("reset.stall32",  64'(bus32.load_stall), 64'd0);
        cmp("reset.stall64",  64'(bus64.load_stall), 64'd0);
        cmp("reset.rdv32",    64'(bus32.rd_v), 64'd0);
        cmp("reset.rdv64",    bus64.rd_v, 64'd0);
        cmp("reset.order32",  64'(bus32.order), 64'd0);
        cmp("reset.order64",  bus64.order, 64'd0);
        driveInputs(st(1'b0, 1'b0, 3'd0, 3'd0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n  = 1'b1;
        m_pend = 1'b0;
        m_held = 1'b0;
    endtask

    initial begin
        stim_t idle;
        stim_t s;
        exp_t  e;

        idle = st(1'b0, 1'b0, 3'd0, 3'd0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        driveInputs(idle);

        vecs[0]  = vec("alu",      st(1'b1, 1'b0, 3'd0, 3'd0, 64'h1234_5678, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0),
                       mk(1'b1, 1'b0, 64'h1234_5678, 64'h1234_5678, 1'b1, 1'b1));
        vecs[1]  = vec("lb_a3",    st(1'b1, 1'b1, 3'd0, 3'd3, 64'h0, 64'h80FF_0000, 5'd6, 1'b1, 1'b1, 1'b0),
                       mk(1'b1, 1'b0, 64'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b1));
        vecs[2]  = vec("lbu_a3",   st(1'b1, 1'b1, 3'd4, 3'd3, 64'h0, 64'h80FF_0000, 5'd6, 1'b1, 1'b1, 1'b0),
                       mk(1'b1, 1'b0, 64'h80, 64'h80, 1'b1, 1'b1));
        vecs[3]  = vec("lw_a4",    st(1'b1, 1'b1, 3'd2, 3'd4, 64'h0, 64'h8000_0000_0000_0000, 5'd7, 1'b1, 1'b1, 1'b0),
                       mk(1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1));
        vecs[4]  = vec("ld",       st(1'b1, 1'b1, 3'd3, 3'd0, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd8, 1'b1, 1'b1, 1'b0),
                       mk(1'b1, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1));
        vecs[5]  = vec("lhu_a2",   st(1'b1, 1'b1, 3'd5, 3'd2, 64'h0, 64'hBEEF_0000, 5'd9, 1'b1, 1'b1, 1'b0),
                       mk(1'b1, 1'b0, 64'hBEEF, 64'hBEEF, 1'b1, 1'b1));
        vecs[6]  = vec("lh_a6",    st(1'b1, 1'b1, 3'd1, 3'd6, 64'h0, 64'h8001_0000_0000_0000, 5'd10, 1'b1, 1'b1, 1'b0),
                       mk(1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b1));
        vecs[7]  = vec("frozen",   st(1'b1, 1'b0, 3'd0, 3'd0, 64'h55, 64'h0, 5'd11, 1'b1, 1'b0, 1'b1),
                       mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0));
        vecs[8]  = vec("alu_nowe", st(1'b1, 1'b0, 3'd0, 3'd0, 64'hDEAD_BEEF_CAFE_BABE, 64'h0, 5'd12, 1'b0, 1'b0, 1'b0),
                       mk(1'b1, 1'b0, 64'hCAFE_BABE, 64'hDEAD_BEEF_CAFE_BABE, 1'b0, 1'b0));
        vecs[9]  = vec("lwu_a4",   st(1'b1, 1'b1, 3'd6, 3'd4, 64'h0, 64'hFFFF_FFFF_0000_0000, 5'd13, 1'b1, 1'b1, 1'b0),
                       mk(1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF, 1'b0, 1'b1));
        vecs[10] = vec("f3_7",     st(1'b1, 1'b1, 3'd7, 3'd0, 64'h0, 64'h1234, 5'd14, 1'b1, 1'b1, 1'b0),
                       mk(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0));
        vecs[11] = vec("stray",    st(1'b0, 1'b1, 3'd2, 3'd0, 64'h0, 64'h9999, 5'd15, 1'b1, 1'b1, 1'b0),
                       mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0));

        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput(vecs[i].name, vecs[i].e);
        end

        // Late response: three stalled cycles, commit only when data arrives.
        s = st(1'b1, 1'b1, 3'd2, 3'd0, 64'h0, 64'h0, 5'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkOutput("late.wait", mk(1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0));
        end
        s.resp = 1'b1;
        s.rdata = 64'hCAFE_F00D;
        applyStimulus(s);
        checkOutput("late.resp", mk(1'b1, 1'b1, 64'hCAFE_F00D, 64'hFFFF_FFFF_CAFE_F00D, 1'b1, 1'b1));
        applyStimulus(idle);
        checkOutput("late.idle", mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0));

        // Response under freeze is held, later responses ignored, commit after freeze drops.
        s = st(1'b1, 1'b1, 3'd5, 3'd2, 64'h0, 64'hBEEF_0000, 5'd9, 1'b1, 1'b1, 1'b1);
        applyStimulus(s);
        checkOutput("hold.capture", mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0));
        s.resp = 1'b0;
        s.rdata = 64'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(s);
            checkOutput("hold.frozen", mk(1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0));
        end
        s.freeze = 1'b0;
        s.resp = 1'b1;
        s.rdata = 64'h1111_1111;
        applyStimulus(s);
        checkOutput("hold.commit", mk(1'b1, 1'b1, 64'hBEEF, 64'hBEEF, 1'b1, 1'b1));
        applyStimulus(idle);
        checkOutput("hold.idle", mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0));

        // Reset while waiting abandons the load.
        s = st(1'b1, 1'b1, 3'd2, 3'd0, 64'h0, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0);
        applyStimulus(s);
        checkOutput("rst.wait", mk(1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0));
        doReset();
        applyStimulus(st(1'b0, 1'b0, 3'd2, 3'd0, 64'h0, 64'hABCD, 5'd4, 1'b1, 1'b1, 1'b0));
        checkOutput("rst.after", mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0));
        applyStimulus(st(1'b1, 1'b0, 3'd0, 3'd0, 64'h55, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0));
        checkOutput("rst.alu", mk(1'b1, 1'b0, 64'h55, 64'h55, 1'b1, 1'b1));
        applyStimulus(idle);
        checkOutput("rst.order", mk(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0));

`ifdef WB_MISALIGN_CHK_EN
        applyStimulus(st(1'b1, 1'b1, 3'd2, 3'd1, 64'h0, 64'h4433_2211, 5'd2, 1'b1, 1'b1, 1'b0));
        e = mk(1'b1, 1'b0, 64'h4433_2211, 64'h4433_2211, 1'b0, 1'b0);
        e.mis32 = 1'b1;
        e.mis64 = 1'b1;
        checkOutput("misalign.lw", e);
`endif

        // Random traffic; inputs held steady while a load is outstanding.
        doReset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99, 0) < 2) begin
                doReset();
                continue;
            end
            if (!(m_pend || m_held)) begin
                cur.in_valid = ($urandom_range(99, 0) < 80);
                cur.is_load  = ($urandom_range(99, 0) < 60);
                cur.funct3   = 3'($urandom_range(7, 0));
                cur.addr     = 3'($urandom_range(7, 0));
                cur.alu      = {$urandom, $urandom};
                cur.rd       = 5'($urandom_range(31, 0));
                cur.we_in    = 1'($urandom_range(1, 0));
            end
            cur.rdata  = {$urandom, $urandom};
            cur.resp   = ($urandom_range(99, 0) < 40);
            cur.freeze = ($urandom_range(99, 0) < 25);
            s = cur;
            applyStimulus(s);
            modelStep(s, e);
            checkOutput("rand", e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
